// File: rtl/digital_tube_mux.sv
// digital_tube_mux: multiplexed N-digit 7-segment driver with buffered loads, blanking, lz-suppression, PWM and dead time
module digital_tube_mux #(
  parameter int DIGITS = 4,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int SCAN_HZ = 1000,
  parameter int DEAD = 8,
  parameter int PWM_BITS = 3,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  I_sys_clk,
  input  logic                  I_rst_n,
  input  logic                  I_en,
  input  logic                  I_load,
  input  logic [4*DIGITS-1:0]   I_disp_data,
  input  logic [DIGITS-1:0]     I_dp,
  input  logic [DIGITS-1:0]     I_blank,
  input  logic                  I_lz_suppress,
  input  logic [PWM_BITS-1:0]   I_bright,
  output logic [DIGITS-1:0]     O_sel,
  output logic [7:0]            O_seg,
  output logic                  O_ack,
  output logic                  O_frame
);
  localparam int DWELL = CLK_FREQ_HZ / SCAN_HZ;
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACTIVE_LOW != 0}};
  localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW != 0}};
  localparam logic [111:0] HEX = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                  7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [PWM_BITS-1:0] pwm;
  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0] pend_dp, pend_blank, act_dp, act_blank, zero_up;
  logic pend_lz, act_lz, pend_v;
  logic wrap, frame_end, apply, lit;
  logic [3:0] nib;
  always_comb begin
    logic z;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z && act_data[4*i +: 4] == 4'd0;
      zero_up[i] = z;
    end
    wrap = cnt == CNT_LAST;
    frame_end = I_en && wrap && idx == IDX_LAST;
    apply = I_en ? frame_end && (pend_v || I_load) : pend_v;
    nib = act_data[4*idx +: 4];
    lit = I_en && cnt >= CNT_DEAD && !act_blank[idx] && !(act_lz && idx != '0 && zero_up[idx]) && pwm <= I_bright;
  end
  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      cnt <= '0;
      idx <= '0;
      pwm <= '0;
      pend_data <= '0;
      pend_dp <= '0;
      pend_blank <= '0;
      pend_lz <= 1'b0;
      pend_v <= 1'b0;
      act_data <= '0;
      act_dp <= '0;
      act_blank <= '0;
      act_lz <= 1'b0;
      O_sel <= SEL_OFF;
      O_seg <= SEG_OFF;
      O_ack <= 1'b0;
      O_frame <= 1'b0;
    end else begin
      cnt <= I_en && !wrap ? cnt + 1'b1 : '0;
      idx <= !I_en ? '0 : !wrap ? idx : idx == IDX_LAST ? '0 : idx + 1'b1;
      pwm <= I_en ? pwm + 1'b1 : '0;
      O_sel <= lit ? SEL_OFF ^ (DIGITS'(1) << idx) : SEL_OFF;
      O_seg <= lit ? SEG_OFF ^ {act_dp[idx], HEX[7*nib +: 7]} : SEG_OFF;
      O_ack <= apply;
      O_frame <= frame_end;
      // a load landing on the frame boundary bypasses pending so it is acked exactly once
      if (apply) begin
        act_data <= I_en && I_load ? I_disp_data : pend_data;
        act_dp <= I_en && I_load ? I_dp : pend_dp;
        act_blank <= I_en && I_load ? I_blank : pend_blank;
        act_lz <= I_en && I_load ? I_lz_suppress : pend_lz;
      end
      if (I_load) begin
        pend_data <= I_disp_data;
        pend_dp <= I_dp;
        pend_blank <= I_blank;
        pend_lz <= I_lz_suppress;
      end
      pend_v <= (I_load && !(apply && I_en)) || (pend_v && !apply);
    end
  end
endmodule

// File: tb/tb_digital_tube_mux.sv
// tb_digital_tube_mux: table vectors, hand sequences and random stimulus checked against a position-based model
module tb_digital_tube_mux;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0, lz = 1'b0;
  logic [15:0] data = '0;
  logic [3:0] dp = '0, blank = '0;
  logic [2:0] bright = 3'd7;
  logic [3:0] sel;
  logic [7:0] seg;
  logic ack, frame;
  int total = 0, bad = 0;
  digital_tube_mux #(.DIGITS(4), .CLK_FREQ_HZ(1000), .SCAN_HZ(100), .DEAD(2), .PWM_BITS(3),
                     .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_load(load), .I_disp_data(data),
    .I_dp(dp), .I_blank(blank), .I_lz_suppress(lz), .I_bright(bright),
    .O_sel(sel), .O_seg(seg), .O_ack(ack), .O_frame(frame));
  always #5 clk = ~clk;
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int m_t;
  logic [15:0] a_data, p_data;
  logic [3:0] a_dp, a_blank, p_dp, p_blank, e_sel;
  logic a_lz, p_lz, p_v, e_ack, e_frame;
  logic [7:0] e_seg;
  logic [7:0] seen [4];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // m_t is the scan position since the last idle: digit, dwell phase and PWM phase follow from it
  task automatic model();
    int d, ph, pw;
    logic bnd, lit;
    if (!rst_n) begin
      m_t = 0;
      {a_data, a_dp, a_blank, a_lz, p_data, p_dp, p_blank, p_lz, p_v} = '0;
      {e_sel, e_seg, e_ack, e_frame} = {4'hF, 8'hFF, 2'b00};
    end else begin
      d = (m_t / 10) % 4;
      ph = m_t % 10;
      pw = m_t % 8;
      bnd = en && m_t % 40 == 39;
      lit = en && ph >= 2 && !a_blank[d] && !(a_lz && d != 0 && (a_data >> (4 * d)) == 0) && pw <= int'(bright);
      e_sel = lit ? ~(4'b1 << d) : 4'hF;
      e_seg = lit ? ~{a_dp[d], hex_tab[a_data[4*d +: 4]]} : 8'hFF;
      e_frame = bnd;
      e_ack = en ? bnd && (p_v || load) : p_v;
      if (bnd && load) begin
        {a_data, a_dp, a_blank, a_lz} = {data, dp, blank, lz};
        p_v = 1'b0;
      end else begin
        if (e_ack) begin
          {a_data, a_dp, a_blank, a_lz} = {p_data, p_dp, p_blank, p_lz};
          p_v = 1'b0;
        end
        if (load) begin
          {p_data, p_dp, p_blank, p_lz} = {data, dp, blank, lz};
          p_v = 1'b1;
        end
      end
      m_t = en ? m_t + 1 : 0;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    check("pins", {18'd0, frame, ack, seg, sel}, {18'd0, e_frame, e_ack, e_seg, e_sel});
  endtask
  task automatic run_frame();
    for (int k = 0; k < 4; k++) seen[k] = 8'h00;
    for (int n = 0; n < 40; n++) begin
      step();
      for (int k = 0; k < 4; k++) if (!sel[k]) seen[k] = ~seg;
    end
  endtask
  task automatic load_once(input logic [15:0] v);
    data = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask
  task automatic wait_ack(input string name);
    int n;
    n = 0;
    while (!ack && n < 60) begin
      step();
      n++;
    end
    check({name, "_ack_seen"}, {31'd0, ack}, 32'd1);
    check({name, "_ack_on_frame"}, {31'd0, frame}, 32'd1);
  endtask
  typedef struct packed {
    logic [15:0] data;
    logic [3:0] dp;
    logic [3:0] blank;
    logic lz;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [6];
  initial begin
    int cnt, first, last, lit_n;
    vecs[0] = '{16'hEC1D, 4'b0000, 4'b0000, 1'b0, 32'h79_39_06_5E};
    vecs[1] = '{16'h0042, 4'b0000, 4'b0000, 1'b1, 32'h00_00_66_5B};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 32'h00_00_00_3F};
    vecs[3] = '{16'h1234, 4'b0100, 4'b0001, 1'b0, 32'h06_DB_4F_00};
    vecs[4] = '{16'h0042, 4'b0000, 4'b0000, 1'b0, 32'h3F_3F_66_5B};
    vecs[5] = '{16'h0F08, 4'b1000, 4'b0000, 1'b1, 32'h00_71_3F_7F};
    @(negedge clk);
    step();
    step();
    check("reset_pins", {18'd0, frame, ack, seg, sel}, {18'd0, 2'b00, 8'hFF, 4'hF});
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en = 1'b0;
      {dp, blank, lz} = {vecs[i].dp, vecs[i].blank, vecs[i].lz};
      load_once(vecs[i].data);
      step();
      step();
      en = 1'b1;
      run_frame();
      for (int k = 0; k < 4; k++) check($sformatf("vec%0d_digit%0d", i, k), {24'd0, seen[k]}, {24'd0, vecs[i].exp[8*k +: 8]});
    end
    en = 1'b0;
    {dp, blank, lz} = '0;
    load_once(16'hEC1D);
    step();
    en = 1'b1;
    cnt = 0;
    first = 0;
    last = 0;
    for (int n = 1; n <= 120; n++) begin
      step();
      if (frame) begin
        if (cnt == 0) first = n;
        else check("frame_spacing", n - last, 40);
        cnt++;
        last = n;
      end
    end
    check("frame_count", cnt, 3);
    check("frame_first", first, 40);
    for (int n = 0; n < 13; n++) step();
    load_once(16'h1234);
    wait_ack("midload");
    run_frame();
    check("midload_d0", {24'd0, seen[0]}, 32'h66);
    check("midload_d3", {24'd0, seen[3]}, 32'h06);
    for (int n = 0; n < 5; n++) step();
    load_once(16'h1111);
    for (int n = 0; n < 7; n++) step();
    load_once(16'h5678);
    wait_ack("twoload");
    run_frame();
    check("twoload_d0", {24'd0, seen[0]}, 32'h7F);
    check("twoload_d3", {24'd0, seen[3]}, 32'h6D);
    en = 1'b0;
    bright = 3'd1;
    step();
    en = 1'b1;
    lit_n = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (sel != 4'hF) lit_n++;
    end
    check("pwm_lit_cycles", lit_n, 8);
    bright = 3'd7;
    for (int n = 0; n < 15; n++) step();
    en = 1'b0;
    step();
    check("en_drop_off", {19'd0, frame, seg, sel}, {19'd0, 1'b0, 8'hFF, 4'hF});
    en = 1'b1;
    for (int n = 0; n < 15; n++) step();
    rst_n = 1'b0;
    step();
    check("reset_mid_scan", {18'd0, frame, ack, seg, sel}, {18'd0, 2'b00, 8'hFF, 4'hF});
    rst_n = 1'b1;
    step();
    step();
    check("restart_dead", {18'd0, frame, ack, sel, seg}, {18'd0, 2'b00, 4'hF, 8'hFF});
    step();
    check("restart_digit0", {20'd0, sel, seg}, {20'd0, 4'hE, 8'hC0});
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) en = ~en;
      load = $urandom_range(29) == 0;
      if (load) begin
        data = 16'($urandom);
        if ($urandom_range(2) == 0) data[15:8] = 8'h00;
        dp = 4'($urandom);
        blank = $urandom_range(3) == 0 ? 4'($urandom) : 4'h0;
        lz = 1'($urandom);
      end
      if ($urandom_range(49) == 0) bright = 3'($urandom);
      rst_n = $urandom_range(499) != 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/digital_tube_mux.md
Name: digital_tube_mux

Overview:
Parametrised multiplexed N-digit 7-segment display driver. It is the successor to the fixed 4-digit tube driver. It adds configurable digit count and polarity, double-buffered tear-free loading with an ack handshake, per-digit decimal point and blanking, leading-zero suppression, PWM brightness, anti-ghost dead time and a frame strobe. It sits between the test-top data registers and the board tube pins; the measurement controller samples O_sel/O_seg/O_frame.

Parameters:
DIGITS, 4, number of digits (1..8); digit 0 = least significant, scanned first
CLK_FREQ_HZ, 50000000, I_sys_clk frequency
SCAN_HZ, 1000, per-digit dwell rate; DWELL = CLK_FREQ_HZ/SCAN_HZ cycles (DWELL > DEAD required)
DEAD, 8, cycles at dwell start with all selects off
PWM_BITS, 3, brightness resolution
SEL_ACTIVE_LOW, 1, 1 = O_sel active-low
SEG_ACTIVE_LOW, 1, 1 = O_seg active-low

Ports:
I_sys_clk  in  1  system clock; sole clock
I_rst_n  in  1  reset; synchronous, active-low
I_en  in  1  scan enable
I_load  in  1  one-cycle request: capture display inputs into pending buffer
I_disp_data  in  4*DIGITS  hex nibbles; nibble i = digit i
I_dp  in  DIGITS  decimal point per digit
I_blank  in  DIGITS  force digit i dark
I_lz_suppress  in  1  enable leading-zero suppression
I_bright  in  PWM_BITS  brightness; all-ones = full on
O_sel  out  DIGITS  one-hot digit select (polarity per SEL_ACTIVE_LOW)
O_seg  out  8  {dp,g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
O_ack  out  1  one-cycle pulse when pending data becomes active
O_frame  out  1  one-cycle pulse when digit DIGITS-1 dwell ends

Behaviour:
- Reset (I_rst_n=0 at clock edge): O_sel and O_seg all inactive (all-ones if active-low); O_ack=0, O_frame=0; active/pending buffers, dwell counter, digit index and PWM counter cleared; pending flag cleared.
- States: IDLE (I_en=0) and SCAN (I_en=1). In IDLE, outputs are inactive and counters are held at 0. IDLE->SCAN starts a dwell at digit 0, cycle 0. Deasserting I_en mid-dwell forces outputs inactive on the next edge and resets the index to 0; no O_frame is issued.
- Dwell counter runs 0..DWELL-1, then wraps; the index advances on wrap, modulo DIGITS. On the wrap from DIGITS-1 to 0, O_frame=1 for one cycle.
- Load: I_load stores data, dp, blank and lz flags into pending and sets the pending flag. A later I_load before application overwrites pending (latest wins). Pending is copied to active at the frame boundary, or on the next cycle when in IDLE; O_ack pulses in that copy cycle. I_load in the boundary cycle itself is copied directly that boundary, and O_ack is pulsed once. I_bright is used live and is not buffered.
- Digit i is dark if any of: dwell count < DEAD; active blank[i]=1; suppression active and i != 0 and all active nibbles DIGITS-1..i equal 0; PWM gate off.
- PWM: free-running PWM_BITS counter incremented every cycle in SCAN; gate on when counter <= I_bright.
- Lit digit: select bit i asserted; seg[6:0] = standard hex decode of nibble i (0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71, active-high form); seg[7] = dp[i]. Apply polarity inversion last. Dark digit: all selects and segments inactive.
- All outputs are registered, with one cycle from counter state to pins. At most one select bit is asserted in any cycle.

Test Plan:
- DIGITS=4, CLK_FREQ_HZ=1000, SCAN_HZ=100 (DWELL=10), DEAD=2, I_bright=7. Load 16'hEC1D, I_en=1 -> digits 0..3 show seg 0x5E,0x06,0x39,0x79 (inverted on pins). Each select is active for 8 cycles after 2 dark cycles. O_frame pulses every 40 cycles.
- Load 16'h0042 with I_lz_suppress=1 -> digits 3 and 2 dark, digits 1 and 0 show 4 and 2. Load 16'h0000 -> only digit 0 shows 0.
- Issue I_load mid-frame with 16'h1234 -> display unchanged until the boundary. O_ack coincides with O_frame, and the next frame shows 1234. Two loads in one frame -> only the second is displayed.
- I_bright=1 -> select active only when the PWM count is 0..1, i.e. 2 of every 8 cycles outside dead time.
- I_dp=4'b0100 and I_blank=4'b0001 -> digit 2 has seg[7] lit and digit 0 is fully dark.
- Drop I_en mid-dwell, then assert I_rst_n=0 for one cycle during scan -> outputs inactive on the next edge. Restart begins at digit 0 with counters at 0 and no stale O_ack/O_frame.
